// File: rtl/io_read_port_mux_pkg.sv
// Shared Tramelblaze port-map definitions: bus width, channel layout and the
// port_id decoder used by both the input-port mux and the output-port decoder.
package io_port_pkg;

    localparam int IN_PORT_W = 16;
    localparam int DATA_OFS  = 0;
    localparam int STAT_OFS  = 1;
    localparam int CH_STRIDE = 2;

    typedef struct packed {
        logic       valid;
        logic       is_status;
        logic [3:0] ch;
    } port_dec_t;

    // The 9-bit subtraction makes a port_id below the base land in the borrow bit.
    function automatic port_dec_t decode_port(input logic [7:0] port_id,
                                              input logic [7:0] base,
                                              input int         num_ch);
        logic [8:0] ofs;
        logic [7:0] idx;
        logic [7:0] field;
        port_dec_t  dec;
        ofs           = {1'b0, port_id} - {1'b0, base};
        idx           = ofs[7:0] / 8'(CH_STRIDE);
        field         = ofs[7:0] % 8'(CH_STRIDE);
        dec.valid     = !ofs[8] && (int'(idx) < num_ch);
        dec.is_status = (field == 8'(STAT_OFS));
        dec.ch        = idx[3:0];
        return dec;
    endfunction

endpackage

// File: rtl/io_read_port_mux_if.sv
// CPU input-port bus: Tramelblaze read address/strobe, peripheral register
// buses in, and the registered read data plus read acknowledges out.
interface io_read_port_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int STAT_W = 8
);
    import io_port_pkg::*;

    logic [7:0]               port_id;
    logic                     read_strobe;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH*STAT_W-1:0] status_in;
    logic [IN_PORT_W-1:0]     in_port;
    logic [NUM_CH-1:0]        data_rd_ack;
    logic [NUM_CH-1:0]        status_rd_ack;

    modport master (
        output port_id, read_strobe, data_in, status_in,
        input  in_port, data_rd_ack, status_rd_ack
    );

    modport slave (
        input  port_id, read_strobe, data_in, status_in,
        output in_port, data_rd_ack, status_rd_ack
    );

endinterface

// File: rtl/io_read_port_mux_sticky.sv
// Per-channel status register: masked bits latch events until a status read,
// unmasked bits pass the live status straight through.
module sticky_status_reg #(
    parameter int                STAT_W      = 8,
    parameter logic [STAT_W-1:0] STICKY_MASK = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [STAT_W-1:0] status_in,
    input  logic              clr,
    output logic [STAT_W-1:0] eff_status
);

    logic [STAT_W-1:0] sticky_q;
    logic [STAT_W-1:0] sticky_d;

    // A new event arriving on the clearing edge survives the clear.
    always_comb begin
        sticky_d = (clr ? '0 : sticky_q) | (status_in & STICKY_MASK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign eff_status = (status_in & ~STICKY_MASK) | (sticky_q & STICKY_MASK);

endmodule

// File: rtl/io_read_port_mux.sv
// Tramelblaze input-port block: decodes port_id onto NUM_CH data/status register
// pairs, registers the selected value onto in_port and pulses read acknowledges.
module io_read_port_mux
    import io_port_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                DATA_W      = 8,
    parameter int                STAT_W      = 8,
    parameter logic [7:0]        BASE_ADDR   = 8'h00,
    parameter logic [STAT_W-1:0] STICKY_MASK = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    io_read_port_mux_if.slave  bus
);

    if (int'(BASE_ADDR) + CH_STRIDE * NUM_CH > 256) begin : g_chk_addr
        $error("io_read_port_mux: register map runs past port_id 255");
    end
    if (DATA_W > IN_PORT_W || STAT_W > IN_PORT_W) begin : g_chk_width
        $error("io_read_port_mux: DATA_W and STAT_W must not exceed 16");
    end

    port_dec_t            dec;
    logic [STAT_W-1:0]    eff_status [NUM_CH];
    logic [IN_PORT_W-1:0] in_port_d, in_port_q;
    logic [NUM_CH-1:0]    data_ack_d, data_ack_q;
    logic [NUM_CH-1:0]    stat_ack_d, stat_ack_q;

    assign dec = decode_port(bus.port_id, BASE_ADDR, NUM_CH);

    // A strobed status read is also the clear request for that channel's sticky bits.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sticky_status_reg #(
            .STAT_W      (STAT_W),
            .STICKY_MASK (STICKY_MASK)
        ) u_sticky (
            .clk        (clk),
            .reset_n    (reset_n),
            .status_in  (bus.status_in[k*STAT_W +: STAT_W]),
            .clr        (stat_ack_d[k]),
            .eff_status (eff_status[k])
        );
    end

    always_comb begin
        in_port_d  = '0;
        data_ack_d = '0;
        stat_ack_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dec.valid && dec.ch == 4'(k)) begin
                if (dec.is_status) begin
                    in_port_d     = IN_PORT_W'(eff_status[k]);
                    stat_ack_d[k] = bus.read_strobe;
                end else begin
                    in_port_d     = IN_PORT_W'(bus.data_in[k*DATA_W +: DATA_W]);
                    data_ack_d[k] = bus.read_strobe;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_port_q  <= '0;
            data_ack_q <= '0;
            stat_ack_q <= '0;
        end else begin
            in_port_q  <= in_port_d;
            data_ack_q <= data_ack_d;
            stat_ack_q <= stat_ack_d;
        end
    end

    assign bus.in_port       = in_port_q;
    assign bus.data_rd_ack   = data_ack_q;
    assign bus.status_rd_ack = stat_ack_q;

endmodule

// File: doc/io_read_port_mux.md
Name: io_read_port_mux

Overview:
- Parametrised CPU input-port block for the Tramelblaze: presents the data and status registers of NUM_CH peripherals (UART channels, timers) on the 16-bit in_port bus, selected by port_id.
- Generalises the single-channel data/status selector:
  - per-channel address decode
  - registered read path
  - read-acknowledge pulses for clear-on-read peripherals
  - sticky status bits that latch events until software reads them

Parameters:
- NUM_CH, 4, number of peripheral channels (1..16).
- DATA_W, 8, data register width per channel (1..16), zero-extended to 16.
- STAT_W, 8, status register width per channel (1..16), zero-extended to 16.
- BASE_ADDR, 8'h00, port_id of channel 0 data register; must be even.
- STICKY_MASK, {STAT_W{1'b0}}, status bits latched as sticky, common to all channels.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- port_id  in  8  Tramelblaze port address.
- read_strobe  in  1  Tramelblaze read qualifier, one cycle per INPUT instruction.
- data_in  in  NUM_CH*DATA_W  channel data, channel k at bits [k*DATA_W +: DATA_W].
- status_in  in  NUM_CH*STAT_W  live channel status, same packing.
- in_port  out  16  registered read data to the Tramelblaze.
- data_rd_ack  out  NUM_CH  one-cycle pulse: channel data register was read.
- status_rd_ack  out  NUM_CH  one-cycle pulse: channel status register was read.

Behaviour:
- Address map:
  - port_id == BASE_ADDR + 2k selects channel k data.
  - port_id == BASE_ADDR + 2k + 1 selects channel k status.
  - Any other port_id is unmapped.
- Reset (reset_n low, asynchronous): in_port = 16'h0000, data_rd_ack = 0, status_rd_ack = 0, all sticky bits = 0.
  - Deassertion is synchronous to clk; no read side effect occurs in the first cycle after release.
- Read path, 1-cycle latency, independent of read_strobe. Every rising edge: in_port <= value selected by the current port_id.
  - Data selection: {zeros, data_in[k]}.
  - Status selection: {zeros, eff_status[k]}.
  - Unmapped selection: 16'h0000.
- Effective status:
  - eff_status[k] = (status_in[k] & ~STICKY_MASK) | (sticky[k] & STICKY_MASK).
- Sticky bits (per channel, per masked bit):
  - Set when status_in bit is 1.
  - Cleared on the edge after a status read of that channel: read_strobe == 1 and port_id selects channel k status.
  - Set and clear in the same cycle: set wins, so an event is never lost; the value returned by that read is the pre-edge value.
- Acknowledge pulses: registered, asserted the cycle after read_strobe, exactly one cycle wide per strobe.
  - data_rd_ack[k] = 1 iff read_strobe and port_id selects channel k data.
  - status_rd_ack[k] = 1 iff read_strobe and port_id selects channel k status.
- Back-to-back read_strobe cycles produce back-to-back pulses; the ack outputs are one-hot or zero.
- read_strobe with an unmapped port_id: no pulse, no sticky change, in_port = 0.
- Reset asserted mid-read: pending pulses and sticky state are discarded immediately.
- STICKY_MASK all zero degenerates to a pure registered mux plus acks.
- Elaboration checks:
  - Flag BASE_ADDR + 2*NUM_CH > 256 as an error.
  - Flag DATA_W > 16 or STAT_W > 16 as an error.

Decomposition:
- Shared package io_port_pkg:
  - IN_PORT_W = 16
  - DATA_OFS = 0
  - STAT_OFS = 1
  - CH_STRIDE = 2
  - function decode_port(port_id, base) returning {valid, is_status, ch_index}, reused by the output-port decoder.
- One sub-module: sticky_status_reg, one instance per channel.
  - Ports: clk, reset_n, status_in, clr, eff_status.
  - Parameters: STAT_W, STICKY_MASK.
- Decode, output register and ack registers live in the top.

Test Plan:
- Reset: hold reset_n = 0 with status_in all 1 -> in_port = 0, acks = 0; release; port_id = 8'h03, no strobe -> in_port = 16'h00FF one cycle later, no status_rd_ack.
- Data read, NUM_CH = 4, BASE = 0: data_in ch2 = 8'hA5, port_id = 8'h04, read_strobe pulse -> in_port = 16'h00A5 next cycle, data_rd_ack = 4'b0100 for exactly one cycle.
- Sticky set and clear, STICKY_MASK = 8'h02:
  - Pulse status_in ch1 bit1 for one cycle, then drop it; read port 8'h03 -> in_port = 16'h0002, status_rd_ack = 4'b0010.
  - Second read -> 16'h0000.
- Set/clear collision: bit1 pulses on ch0 in the same cycle as a status read of port 8'h01 -> that read returns bit1 = 0; the next read returns 16'h0002.
- Unmapped read: port_id = 8'h08 with NUM_CH = 4 and read_strobe -> in_port = 0, no ack, sticky state unchanged.
- Async reset mid-read: sticky bit set, assert reset_n low between clock edges -> in_port and ack go 0 immediately; after release, a status read returns 16'h0000.
